// File: rtl/hpu_cfg_master.sv
// AXI-Lite initiator that programs the HPU control register file and runs one job start.
// Define HPU_CFG_READBACK_EN to read back and verify each job-parameter write.
module hpu_cfg_master #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [15:0] POLL_MAX  = 16'd65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [19:0] cfg_addr_j,
   input  logic [19:0] cfg_addr_i,
   input  logic [4:0]  cfg_remainder,
   input  logic [15:0] cfg_item_num,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code,
   output logic [31:0] M_AXI_AWADDR,
   output logic        M_AXI_AWVALID,
   input  logic        M_AXI_AWREADY,
   output logic [31:0] M_AXI_WDATA,
   output logic [3:0]  M_AXI_WSTRB,
   output logic        M_AXI_WVALID,
   input  logic        M_AXI_WREADY,
   input  logic [1:0]  M_AXI_BRESP,
   input  logic        M_AXI_BVALID,
   output logic        M_AXI_BREADY,
   output logic [31:0] M_AXI_ARADDR,
   output logic        M_AXI_ARVALID,
   input  logic        M_AXI_ARREADY,
   input  logic [31:0] M_AXI_RDATA,
   input  logic [1:0]  M_AXI_RRESP,
   input  logic        M_AXI_RVALID,
   output logic        M_AXI_RREADY
);

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RESP,
      RD_REQ,
      RD_RESP,
      NEXT,
      DONE,
      ERR
   } state_t;

   localparam logic [1:0] ERR_RESP     = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
   localparam logic [1:0] ERR_READBACK = 2'b11;
   localparam logic [2:0] STEP_POLL    = 3'd6;
   localparam logic [2:0] STEP_RUN     = 3'd7;

   state_t      state_q, state_d;
   logic [2:0]  step_q, step_d;
   logic        req_sent_q, req_sent_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic [15:0] poll_cnt_q, poll_cnt_d;
   logic [19:0] addr_j_q, addr_j_d;
   logic [19:0] addr_i_q, addr_i_d;
   logic [4:0]  remainder_q, remainder_d;
   logic [15:0] item_num_q, item_num_d;
   logic [31:0] awaddr_q, awaddr_d;
   logic        awvalid_q, awvalid_d;
   logic [31:0] wdata_q, wdata_d;
   logic        wvalid_q, wvalid_d;
   logic        bready_q, bready_d;
   logic [31:0] araddr_q, araddr_d;
   logic        arvalid_q, arvalid_d;
   logic        rready_q, rready_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
   logic [1:0]  err_code_q, err_code_d;

   logic [7:0]  cur_off;
   logic [31:0] cur_wdata;
   logic        aw_fin;
   logic        w_fin;
   logic [16:0] poll_next;
   logic        rb_match;
   logic        rdata_unused;

   // Register offset and write payload for the current step of the job sequence.
   always_comb begin
      cur_off   = 8'h00;
      cur_wdata = 32'd0;
      case (step_q)
         3'd1: begin cur_off = 8'h04; cur_wdata = {12'd0, addr_j_q};    end
         3'd2: begin cur_off = 8'h08; cur_wdata = {12'd0, addr_i_q};    end
         3'd3: begin cur_off = 8'h0C; cur_wdata = {27'd0, remainder_q}; end
         3'd4: begin cur_off = 8'h10; cur_wdata = {16'd0, item_num_q};  end
         3'd5: begin cur_off = 8'h00; cur_wdata = 32'd1;                end
         3'd7: begin cur_off = 8'h00; cur_wdata = 32'd2;                end
         default: begin cur_off = 8'h00; cur_wdata = 32'd0;             end
      endcase
   end

`ifdef HPU_CFG_READBACK_EN
   always_comb begin
      rb_match = 1'b1;
      case (step_q)
         3'd1:    rb_match = (M_AXI_RDATA[19:0] == addr_j_q);
         3'd2:    rb_match = (M_AXI_RDATA[19:0] == addr_i_q);
         3'd3:    rb_match = (M_AXI_RDATA[4:0]  == remainder_q);
         3'd4:    rb_match = (M_AXI_RDATA[15:0] == item_num_q);
         default: rb_match = 1'b1;
      endcase
   end
   assign rdata_unused = ^M_AXI_RDATA[31:20];
`else
   assign rb_match     = 1'b1;
   assign rdata_unused = ^M_AXI_RDATA[31:1];
`endif

   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      req_sent_d  = req_sent_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      poll_cnt_d  = poll_cnt_q;
      addr_j_d    = addr_j_q;
      addr_i_d    = addr_i_q;
      remainder_d = remainder_q;
      item_num_d  = item_num_q;
      awaddr_d    = awaddr_q;
      awvalid_d   = awvalid_q;
      wdata_d     = wdata_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      araddr_d    = araddr_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      error_d     = error_q;
      err_code_d  = err_code_q;
      aw_fin      = aw_done_q | (awvalid_q & M_AXI_AWREADY);
      w_fin       = w_done_q  | (wvalid_q  & M_AXI_WREADY);
      poll_next   = {1'b0, poll_cnt_q} + 17'd1;

      case (state_q)
         IDLE: begin
            if (start) begin
               addr_j_d    = cfg_addr_j;
               addr_i_d    = cfg_addr_i;
               remainder_d = cfg_remainder;
               item_num_d  = cfg_item_num;
               step_d      = 3'd0;
               poll_cnt_d  = 16'd0;
               req_sent_d  = 1'b0;
               busy_d      = 1'b1;
               error_d     = 1'b0;
               err_code_d  = 2'b00;
               state_d     = WR_REQ;
            end
         end

         WR_REQ: begin
            if (!req_sent_q) begin
               awaddr_d   = BASE_ADDR + {24'd0, cur_off};
               wdata_d    = cur_wdata;
               awvalid_d  = 1'b1;
               wvalid_d   = 1'b1;
               aw_done_d  = 1'b0;
               w_done_d   = 1'b0;
               req_sent_d = 1'b1;
            end else begin
               // Address and data channels retire independently of each other.
               if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
               if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
               aw_done_d = aw_fin;
               w_done_d  = w_fin;
               if (aw_fin && w_fin) begin
                  req_sent_d = 1'b0;
                  bready_d   = 1'b1;
                  state_d    = WR_RESP;
               end
            end
         end

         WR_RESP: begin
            if (bready_q && M_AXI_BVALID) begin
               bready_d = 1'b0;
               if (M_AXI_BRESP != 2'b00) begin
                  state_d    = ERR;
                  busy_d     = 1'b0;
                  error_d    = 1'b1;
                  err_code_d = ERR_RESP;
`ifdef HPU_CFG_READBACK_EN
               end else if (step_q >= 3'd1 && step_q <= 3'd4) begin
                  state_d = RD_REQ;
`endif
               end else begin
                  state_d = NEXT;
               end
            end
         end

         RD_REQ: begin
            if (!req_sent_q) begin
               araddr_d   = BASE_ADDR + {24'd0, cur_off};
               arvalid_d  = 1'b1;
               req_sent_d = 1'b1;
            end else if (arvalid_q && M_AXI_ARREADY) begin
               arvalid_d  = 1'b0;
               req_sent_d = 1'b0;
               rready_d   = 1'b1;
               state_d    = RD_RESP;
            end
         end

         RD_RESP: begin
            if (rready_q && M_AXI_RVALID) begin
               rready_d = 1'b0;
               if (M_AXI_RRESP != 2'b00) begin
                  state_d    = ERR;
                  busy_d     = 1'b0;
                  error_d    = 1'b1;
                  err_code_d = ERR_RESP;
               end else if (step_q == STEP_POLL) begin
                  if (M_AXI_RDATA[0]) begin
                     // Counter saturates at the limit rather than wrapping.
                     if (poll_next >= {1'b0, POLL_MAX}) begin
                        poll_cnt_d = POLL_MAX;
                        state_d    = ERR;
                        busy_d     = 1'b0;
                        error_d    = 1'b1;
                        err_code_d = ERR_TIMEOUT;
                     end else begin
                        poll_cnt_d = poll_next[15:0];
                        state_d    = RD_REQ;
                     end
                  end else begin
                     state_d = NEXT;
                  end
               end else if (!rb_match) begin
                  state_d    = ERR;
                  busy_d     = 1'b0;
                  error_d    = 1'b1;
                  err_code_d = ERR_READBACK;
               end else begin
                  state_d = NEXT;
               end
            end
         end

         NEXT: begin
            if (step_q == STEP_RUN) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = DONE;
            end else begin
               step_d     = step_q + 3'd1;
               req_sent_d = 1'b0;
               state_d    = ((step_q + 3'd1) == STEP_POLL) ? RD_REQ : WR_REQ;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         ERR: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         step_q      <= 3'd0;
         req_sent_q  <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         poll_cnt_q  <= 16'd0;
         addr_j_q    <= 20'd0;
         addr_i_q    <= 20'd0;
         remainder_q <= 5'd0;
         item_num_q  <= 16'd0;
         awaddr_q    <= 32'd0;
         awvalid_q   <= 1'b0;
         wdata_q     <= 32'd0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         araddr_q    <= 32'd0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         err_code_q  <= 2'b00;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         req_sent_q  <= req_sent_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         poll_cnt_q  <= poll_cnt_d;
         addr_j_q    <= addr_j_d;
         addr_i_q    <= addr_i_d;
         remainder_q <= remainder_d;
         item_num_q  <= item_num_d;
         awaddr_q    <= awaddr_d;
         awvalid_q   <= awvalid_d;
         wdata_q     <= wdata_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         araddr_q    <= araddr_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         err_code_q  <= err_code_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = error_q;
   assign err_code      = err_code_q;
   assign M_AXI_AWADDR  = awaddr_q;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = 4'hF;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;
   assign M_AXI_ARADDR  = araddr_q;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_hpu_cfg_master.sv
// Directed bench for hpu_cfg_master with a behavioural AXI-Lite register-file slave.
// Expectations adapt when HPU_CFG_READBACK_EN is defined.
module tb_hpu_cfg_master;

   localparam logic [31:0] BASE = 32'h4000_0000;

   logic        clk;
   logic        rst;
   logic        start;
   logic [19:0] cfg_addr_j;
   logic [19:0] cfg_addr_i;
   logic [4:0]  cfg_remainder;
   logic [15:0] cfg_item_num;
   logic        busy, done, error;
   logic [1:0]  err_code;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;

   hpu_cfg_master #(.BASE_ADDR(BASE), .POLL_MAX(16'd4)) dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_addr_j(cfg_addr_j), .cfg_addr_i(cfg_addr_i),
      .cfg_remainder(cfg_remainder), .cfg_item_num(cfg_item_num),
      .busy(busy), .done(done), .error(error), .err_code(err_code),
      .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
      .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
      .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
      .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
      .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave behaviour knobs, driven only by the stimulus block.
   int          aw_delay;
   int          gen_clear_on;
   logic [31:0] bresp_err_off;
   logic [31:0] corrupt_off;
   logic        log_clr;

   // Slave and monitor state.
   logic [31:0] regs [0:4];
   logic        aw_have, w_have;
   logic [31:0] aw_addr_s, w_data_s;
   int          aw_cnt, wr_cnt, rd_cnt, poll_cnt, done_cnt;
   logic [31:0] wr_off_log  [0:15];
   logic [31:0] wr_data_log [0:15];
   int          aw_run, w_run, aw_min, aw_max, w_max;
   logic        aw_unstable, bready_early, strb_bad;
   logic        aw_pend_prev;
   logic [31:0] awaddr_prev;
   logic [31:0] off_w, off_r;

   assign off_w   = aw_addr_s - BASE;
   assign off_r   = araddr - BASE;
   assign awready = (aw_cnt >= aw_delay);
   assign wready  = 1'b1;
   assign arready = 1'b1;

   always @(posedge clk) begin
      if (rst || log_clr) begin
         aw_have <= 1'b0;  w_have <= 1'b0;
         bvalid  <= 1'b0;  bresp  <= 2'b00;
         rvalid  <= 1'b0;  rresp  <= 2'b00;  rdata <= 32'd0;
         aw_cnt  <= 0;     wr_cnt <= 0;      rd_cnt <= 0;
         poll_cnt <= 0;    done_cnt <= 0;
         aw_run  <= 0;     w_run  <= 0;      aw_min <= 1000;  aw_max <= 0;  w_max <= 0;
         aw_unstable <= 1'b0;  bready_early <= 1'b0;  strb_bad <= 1'b0;
         aw_pend_prev <= 1'b0; awaddr_prev <= 32'd0;
      end else begin
         if (awvalid) begin
            if (awready) begin
               aw_have   <= 1'b1;
               aw_addr_s <= awaddr;
               aw_cnt    <= 0;
               aw_run    <= 0;
               if (aw_run + 1 < aw_min) aw_min <= aw_run + 1;
               if (aw_run + 1 > aw_max) aw_max <= aw_run + 1;
            end else begin
               aw_cnt <= aw_cnt + 1;
               aw_run <= aw_run + 1;
            end
         end
         if (wvalid) begin
            if (wstrb != 4'hF) strb_bad <= 1'b1;
            if (wready) begin
               w_have   <= 1'b1;
               w_data_s <= wdata;
               w_run    <= 0;
               if (w_run + 1 > w_max) w_max <= w_run + 1;
            end else begin
               w_run <= w_run + 1;
            end
         end
         if (aw_pend_prev && (!awvalid || awaddr != awaddr_prev)) aw_unstable <= 1'b1;
         aw_pend_prev <= awvalid && !awready;
         awaddr_prev  <= awaddr;
         if (bready && (awvalid || wvalid)) bready_early <= 1'b1;

         if (aw_have && w_have && !bvalid) begin
            if (off_w <= 32'h10) regs[off_w[4:2]] <= w_data_s;
            if (wr_cnt < 16) begin
               wr_off_log[wr_cnt]  <= off_w;
               wr_data_log[wr_cnt] <= w_data_s;
            end
            $display("[%0t] write off=%02h data=%08h", $time, off_w, w_data_s);
            wr_cnt  <= wr_cnt + 1;
            bvalid  <= 1'b1;
            bresp   <= (off_w == bresp_err_off) ? 2'b10 : 2'b00;
            aw_have <= 1'b0;
            w_have  <= 1'b0;
         end
         if (bvalid && bready) bvalid <= 1'b0;

         if (arvalid && arready) begin
            rd_cnt <= rd_cnt + 1;
            rvalid <= 1'b1;
            rresp  <= 2'b00;
            if (off_r == 32'h0) begin
               poll_cnt <= poll_cnt + 1;
               rdata    <= (poll_cnt + 1 < gen_clear_on) ? 32'd1 : 32'd0;
               $display("[%0t] read  off=00 gen=%0d", $time, (poll_cnt + 1 < gen_clear_on));
            end else begin
               rdata <= regs[off_r[4:2]] ^ ((off_r == corrupt_off) ? 32'd1 : 32'd0);
               $display("[%0t] read  off=%02h", $time, off_r);
            end
         end
         if (rvalid && rready) rvalid <= 1'b0;
         if (done) done_cnt <= done_cnt + 1;
      end
   end

   int checks;
   int errors;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         end
   endtask

   task automatic clr_logs();
      @(negedge clk) log_clr = 1'b1;
      @(negedge clk) log_clr = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_end(input string tag);
      int n;
      n = 0;
      while (!(done || error) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_finished"}, (n < 2000), 32'd1);
      repeat (5) @(negedge clk);
   endtask

   logic [31:0] exp_off  [0:6];
   logic [31:0] exp_data [0:6];
   int          rb_extra;

   initial begin
      checks = 0;  errors = 0;
      rst = 1'b1;  start = 1'b0;  log_clr = 1'b0;
      aw_delay = 0;  gen_clear_on = 3;
      bresp_err_off = 32'hFFFF_FFFF;  corrupt_off = 32'hFFFF_FFFF;
      cfg_addr_j = 20'd2;  cfg_addr_i = 20'd9;  cfg_remainder = 5'd20;  cfg_item_num = 16'd1000;
`ifdef HPU_CFG_READBACK_EN
      rb_extra = 1;
`else
      rb_extra = 0;
`endif
      exp_off[0] = 32'h00; exp_data[0] = 32'd0;
      exp_off[1] = 32'h04; exp_data[1] = 32'd2;
      exp_off[2] = 32'h08; exp_data[2] = 32'd9;
      exp_off[3] = 32'h0C; exp_data[3] = 32'd20;
      exp_off[4] = 32'h10; exp_data[4] = 32'd1000;
      exp_off[5] = 32'h00; exp_data[5] = 32'd1;
      exp_off[6] = 32'h00; exp_data[6] = 32'd2;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_err_code", err_code, 0);
      check("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
      check("rst_awaddr", awaddr, 0);
      check("rst_wdata", wdata, 0);
      check("rst_araddr", araddr, 0);
      rst = 1'b0;
      clr_logs();

      // Ideal slave, gen clears on third poll
      pulse_start();
      check("t1_busy_after_start", busy, 1);
      wait_end("t1");
      check("t1_done_cnt", done_cnt, 1);
      check("t1_error", error, 0);
      check("t1_busy_end", busy, 0);
      check("t1_wr_cnt", wr_cnt, 7);
      check("t1_poll_reads", poll_cnt, 3);
      check("t1_rd_cnt", rd_cnt, 3 + 4 * rb_extra);
      check("t1_strb", strb_bad, 0);
      for (int i = 0; i < 7; i++) begin
         check($sformatf("t1_wr%0d_off", i), wr_off_log[i], exp_off[i]);
         check($sformatf("t1_wr%0d_data", i), wr_data_log[i], exp_data[i]);
      end
      $display("test ideal: done_cnt=%0d writes=%0d reads=%0d", done_cnt, wr_cnt, rd_cnt);

      // Slow AWREADY, immediate WREADY
      aw_delay = 3;
      clr_logs();
      pulse_start();
      wait_end("t2");
      check("t2_done_cnt", done_cnt, 1);
      check("t2_wr_cnt", wr_cnt, 7);
      check("t2_aw_min", aw_min, 4);
      check("t2_aw_max", aw_max, 4);
      check("t2_w_max", w_max, 1);
      check("t2_aw_stable", aw_unstable, 0);
      check("t2_bready_early", bready_early, 0);
      $display("test slow_aw: aw_len=%0d..%0d w_len=%0d", aw_min, aw_max, w_max);
      aw_delay = 0;

      // SLVERR on the 0x08 write
      bresp_err_off = 32'h08;
      clr_logs();
      pulse_start();
      wait_end("t3");
      repeat (10) @(negedge clk);
      check("t3_error", error, 1);
      check("t3_err_code", err_code, 1);
      check("t3_busy", busy, 0);
      check("t3_done_cnt", done_cnt, 0);
      check("t3_wr_cnt", wr_cnt, 3);
      check("t3_rd_cnt", rd_cnt, rb_extra);
      $display("test bresp: error=%0d code=%0d writes=%0d", error, err_code, wr_cnt);
      bresp_err_off = 32'hFFFF_FFFF;

      // Gen never clears: poll timeout at POLL_MAX=4
      gen_clear_on = 1000;
      clr_logs();
      pulse_start();
      check("t4_error_cleared", error, 0);
      check("t4_code_cleared", err_code, 0);
      wait_end("t4");
      check("t4_error", error, 1);
      check("t4_err_code", err_code, 2);
      check("t4_poll_reads", poll_cnt, 4);
      check("t4_wr_cnt", wr_cnt, 6);
      check("t4_done_cnt", done_cnt, 0);
      $display("test timeout: polls=%0d code=%0d writes=%0d", poll_cnt, err_code, wr_cnt);
      gen_clear_on = 3;

      // Reset during WR_RESP, then a clean run
      clr_logs();
      pulse_start();
      begin
         int n;
         n = 0;
         while (!bready && n < 100) begin
            @(negedge clk);
            n++;
         end
         check("t5_reached_wr_resp", bready, 1);
      end
      rst = 1'b1;
      @(negedge clk);
      check("t5_valids_low", {awvalid, wvalid, bready, arvalid, rready}, 0);
      check("t5_busy_low", busy, 0);
      rst = 1'b0;
      clr_logs();
      pulse_start();
      wait_end("t5");
      check("t5_done_cnt", done_cnt, 1);
      check("t5_wr_cnt", wr_cnt, 7);
      check("t5_error", error, 0);
      check("t5_last_wr", wr_data_log[6], 32'd2);
      $display("test rst_mid: done_cnt=%0d writes=%0d", done_cnt, wr_cnt);

      // Slave corrupts readback of 0x0C
      corrupt_off = 32'h0C;
      clr_logs();
      pulse_start();
      wait_end("t6");
`ifdef HPU_CFG_READBACK_EN
      check("t6_error", error, 1);
      check("t6_err_code", err_code, 3);
      check("t6_wr_cnt", wr_cnt, 4);
      check("t6_rd_cnt", rd_cnt, 3);
      check("t6_done_cnt", done_cnt, 0);
`else
      check("t6_error", error, 0);
      check("t6_done_cnt", done_cnt, 1);
      check("t6_wr_cnt", wr_cnt, 7);
`endif
      $display("test corrupt: error=%0d code=%0d done_cnt=%0d", error, err_code, done_cnt);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hpu_cfg_master.md
Name: hpu_cfg_master

Overview:
- AXI-Lite initiator that programs the HPU accelerator's control register file and sequences a full job start.
- Sequence: clear run/gen, write the four job parameters, pulse item-memory generation, poll until gen self-clears, then set run.
- Sits between a host-side or embedded controller and the accelerator's AXI-Lite slave port, and shares the slave's clock.

Parameters:
- BASE_ADDR, 32'h0000_0000, base address of the accelerator register window; all register offsets are added to it.
- POLL_MAX, 16'd65535, maximum number of status reads before a poll timeout is declared.

Ports:
- clk  in  1  AXI-Lite clock.
- rst  in  1  Reset: synchronous, active-high.
- start  in  1  One-cycle request; accepted only in IDLE.
- cfg_addr_j  in  20  N-gram value; written to offset 0x04.
- cfg_addr_i  in  20  Per-core iteration count; written to offset 0x08.
- cfg_remainder  in  5  Remainder count; written to offset 0x0C.
- cfg_item_num  in  16  Item-memory count; written to offset 0x10.
- busy  out  1  High from the cycle after start acceptance until DONE or ERR.
- done  out  1  One-cycle pulse on successful completion.
- error  out  1  Sticky until the next accepted start.
- err_code  out  2  01 = nonzero BRESP/RRESP, 10 = poll timeout, 11 = readback mismatch.
- M_AXI_AWADDR out 32, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1
- M_AXI_WDATA out 32, M_AXI_WSTRB out 4, M_AXI_WVALID out 1, M_AXI_WREADY in 1
- M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1
- M_AXI_ARADDR out 32, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1
- M_AXI_RDATA in 32, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1

Behaviour:
- Reset values: all VALID/READY outputs, busy, done, error and err_code are 0. Address/data outputs are 0. State is IDLE.
- rst mid-transaction drops every VALID on the next edge; the slave shares the reset.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, NEXT, DONE, ERR.
- Start acceptance: start in IDLE latches all cfg_* inputs and sets step = 0. start outside IDLE is ignored.
- Step list:
  - 0: write 0x00 = 0x0
  - 1: write 0x04 = addr_j
  - 2: write 0x08 = addr_i
  - 3: write 0x0C = remainder
  - 4: write 0x10 = item_num
  - 5: write 0x00 = 0x1 (gen)
  - 6: poll-read 0x00
  - 7: write 0x00 = 0x2 (run)
- Write data formatting: zero-extended to 32 bits; WSTRB = 4'hF always.
- WR_REQ: AWVALID and WVALID rise together one cycle after entry. Each is held stable until its own READY is sampled high, then deasserted independently; aw_done/w_done flags track completion. When both flags are set, enter WR_RESP.
- WR_RESP: BREADY = 1. On BVALID: BRESP != 0 → ERR (code 01); otherwise → NEXT.
- RD_REQ: ARVALID held until ARREADY, then → RD_RESP.
- RD_RESP: RREADY = 1. On RVALID: RRESP != 0 → ERR (code 01).
  - Step 6, RDATA[0] = 1: increment poll_cnt. If poll_cnt reaches POLL_MAX → ERR (code 10); otherwise re-enter RD_REQ.
  - Step 6, RDATA[0] = 0: → NEXT.
- NEXT: step increments; after step 7 → DONE.
- DONE: done = 1 for one cycle, busy drops, → IDLE.
- ERR: VALIDs are already low; busy drops, error = 1, → IDLE. A new start clears error and err_code.
- poll_cnt is 16 bits, cleared at start, and saturates at the compare; there is no wrap-around.
- READY-before-VALID from the slave is legal. Same-cycle AWREADY and WREADY completes both halves in one cycle.
- Only one outstanding transaction at any time.

Optional Feature:
- Macro: HPU_CFG_READBACK_EN.
- Defined: after each successful write in steps 1–4, a read of the same offset is issued. The comparison uses the field width (20/20/5/16 bits); any mismatch → ERR with code 11.
- Undefined: no readback; err_code 11 is never produced and steps 1–4 go straight to NEXT.

Test Plan:
- Ideal slave (READY always high, gen clears on the 3rd poll), start with addr_j=2, addr_i=9, remainder=20, item_num=1000 → writes in order 0x00=0, 0x04=2, 0x08=9, 0x0C=20, 0x10=1000, 0x00=1; 3 reads of 0x00; then 0x00=2; done pulses once.
- AWREADY delayed 3 cycles while WREADY is immediate → WVALID drops after 1 cycle, AWVALID is held 4 cycles with stable address, and BREADY is asserted only after both complete.
- Slave returns BRESP=2'b10 on the 0x08 write → error=1, err_code=01, no further transactions, busy=0.
- gen never clears, POLL_MAX=4 → exactly 4 reads of 0x00, then error with err_code=10 and no run write.
- rst asserted during WR_RESP → next cycle all VALID/READY low and busy=0; a following start runs the full sequence cleanly.
- With HPU_CFG_READBACK_EN, slave corrupts the readback of 0x0C → err_code=11 after that read; without the macro the same slave completes with done.
